// File: rtl/imc_mult.sv
// Sequential 2x2 fixed-point matrix multiplier P = M x N with one shared multiplier.
// M is two's-complement Q8.8; N and P are sign-magnitude Q8.8.
module imc_mult #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] aIn,
    input  logic [W-1:0] bIn,
    input  logic [W-1:0] cIn,
    input  logic [W-1:0] dIn,
    input  logic [W-1:0] eIn,
    input  logic [W-1:0] fIn,
    input  logic [W-1:0] gIn,
    input  logic [W-1:0] hIn,
    input  logic         eIn_sign,
    input  logic         fIn_sign,
    input  logic         gIn_sign,
    input  logic         hIn_sign,
    output logic         ready,
    output logic         done,
    output logic         ovf,
    output logic [W-1:0] aOut,
    output logic [W-1:0] bOut,
    output logic [W-1:0] cOut,
    output logic [W-1:0] dOut,
    output logic         aOut_sign,
    output logic         bOut_sign,
    output logic         cOut_sign,
    output logic         dOut_sign
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // MAC   | k=0..7, one product per cycle into the element accumulators
    // WRAP  | normalize accumulators into the outputs, pulse done
    typedef enum logic [1:0] {IDLE, MAC, WRAP} state_t;

    localparam int AW = 2*W + 2;
    localparam logic [AW-1:0] HALF = AW'(1) << (FRAC-1);

    state_t state, state_nxt;

    logic signed [W-1:0]  m_reg [4];
    logic signed [W:0]    n_reg [4];
    logic signed [AW-1:0] acc   [4];
    logic [2:0]           k;
    logic [W-1:0]         out_mag  [4];
    logic                 out_sign [4];

    logic [1:0]           idx;
    logic                 term;
    logic signed [W-1:0]  m_sel;
    logic signed [W:0]    n_sel;
    logic signed [2*W:0]  m_ext, n_ext, prod;
    logic                 accept;

    logic [W-1:0]         norm_mag  [4];
    logic                 norm_sign [4];
    logic                 norm_sat  [4];

    function automatic logic signed [W:0] to_signed(input logic [W-1:0] mag, input logic neg);
        logic signed [W:0] v;
        v = $signed({1'b0, mag});
        return neg ? -v : v;
    endfunction

    assign accept = start && (state == IDLE);
    assign ready  = (state == IDLE);

    // Row of M follows the element row, column follows the term; N is the transpose of that.
    assign idx   = k[2:1];
    assign term  = k[0];
    assign m_sel = m_reg[{idx[1], term}];
    assign n_sel = n_reg[{term, idx[0]}];
    assign m_ext = {{(W+1){m_sel[W-1]}}, m_sel};
    assign n_ext = {{W{n_sel[W]}}, n_sel};
    assign prod  = m_ext * n_ext;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] mag;
            logic [AW-1:0] rnd;
            mag          = acc[i][AW-1] ? AW'(-acc[i]) : AW'(acc[i]);
            rnd          = (mag + HALF) >> FRAC;
            norm_sat[i]  = |rnd[AW-1:W];
            norm_mag[i]  = norm_sat[i] ? {W{1'b1}} : rnd[W-1:0];
            norm_sign[i] = acc[i][AW-1] && (norm_mag[i] != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (k == 3'd7) state_nxt = WRAP;
            WRAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            done <= 1'b0;
            ovf  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_reg[i]    <= '0;
                n_reg[i]    <= '0;
                acc[i]      <= '0;
                out_mag[i]  <= '0;
                out_sign[i] <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            if (accept) begin
                k        <= '0;
                ovf      <= 1'b0;
                m_reg[0] <= aIn;
                m_reg[1] <= bIn;
                m_reg[2] <= cIn;
                m_reg[3] <= dIn;
                n_reg[0] <= to_signed(eIn, eIn_sign);
                n_reg[1] <= to_signed(fIn, fIn_sign);
                n_reg[2] <= to_signed(gIn, gIn_sign);
                n_reg[3] <= to_signed(hIn, hIn_sign);
            end
            if (state == MAC) begin
                k <= k + 3'd1;
                if (term) acc[idx] <= acc[idx] + {prod[2*W], prod};
                else      acc[idx] <= {prod[2*W], prod};
            end
            if (state == WRAP) begin
                done <= 1'b1;
                ovf  <= norm_sat[0] | norm_sat[1] | norm_sat[2] | norm_sat[3];
                for (int i = 0; i < 4; i++) begin
                    out_mag[i]  <= norm_mag[i];
                    out_sign[i] <= norm_sign[i];
                end
            end
        end
    end

    assign aOut      = out_mag[0];
    assign bOut      = out_mag[1];
    assign cOut      = out_mag[2];
    assign dOut      = out_mag[3];
    assign aOut_sign = out_sign[0];
    assign bOut_sign = out_sign[1];
    assign cOut_sign = out_sign[2];
    assign dOut_sign = out_sign[3];

endmodule

// File: tb/tb_imc_mult.sv
// Directed bench for imc_mult: hand-computed products, rounding, saturation,
// mid-operation start and reset.
module tb_imc_mult;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] aIn, bIn, cIn, dIn, eIn, fIn, gIn, hIn;
    logic        eIn_sign, fIn_sign, gIn_sign, hIn_sign;
    logic        ready, done, ovf;
    logic [15:0] aOut, bOut, cOut, dOut;
    logic        aOut_sign, bOut_sign, cOut_sign, dOut_sign;

    int n_checks = 0;
    int n_errors = 0;
    int low_cycles, dones;

    always #5 clk = ~clk;

    imc_mult #(.W(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .aIn(aIn), .bIn(bIn), .cIn(cIn), .dIn(dIn),
        .eIn(eIn), .fIn(fIn), .gIn(gIn), .hIn(hIn),
        .eIn_sign(eIn_sign), .fIn_sign(fIn_sign), .gIn_sign(gIn_sign), .hIn_sign(hIn_sign),
        .ready(ready), .done(done), .ovf(ovf),
        .aOut(aOut), .bOut(bOut), .cOut(cOut), .dOut(dOut),
        .aOut_sign(aOut_sign), .bOut_sign(bOut_sign), .cOut_sign(cOut_sign), .dOut_sign(dOut_sign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected values packed as {sign, magnitude}.
    task automatic check_p(input string tag, input logic [16:0] ea, input logic [16:0] eb,
                           input logic [16:0] ec, input logic [16:0] ed);
        check({tag, " a"}, {15'd0, aOut_sign, aOut}, {15'd0, ea});
        check({tag, " b"}, {15'd0, bOut_sign, bOut}, {15'd0, eb});
        check({tag, " c"}, {15'd0, cOut_sign, cOut}, {15'd0, ec});
        check({tag, " d"}, {15'd0, dOut_sign, dOut}, {15'd0, ed});
    endtask

    task automatic set_ops(input logic [63:0] mv, input logic [63:0] nv, input logic [3:0] ns);
        {aIn, bIn, cIn, dIn} = mv;
        {eIn, fIn, gIn, hIn} = nv;
        {eIn_sign, fIn_sign, gIn_sign, hIn_sign} = ns;
    endtask

    // Starts from a negedge with ready=1 and returns at the negedge where ready comes back.
    task automatic run_op(output int lows, output int dn);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lows = 0;
        dn = 0;
        while (!ready && lows < 20) begin
            lows++;
            if (done) dn++;
            @(negedge clk);
        end
        if (done) dn++;
    endtask

    task automatic op_and_check(input string tag, input logic [16:0] ea, input logic [16:0] eb,
                                input logic [16:0] ec, input logic [16:0] ed, input logic eovf);
        run_op(low_cycles, dones);
        check({tag, " ready_low"}, low_cycles, 9);
        check({tag, " done"}, {31'd0, done}, 1);
        check_p(tag, ea, eb, ec, ed);
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_ops('0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst ready", {31'd0, ready}, 1);
        check("rst done", {31'd0, done}, 0);
        check("rst ovf", {31'd0, ovf}, 0);
        check_p("rst", 17'h0, 17'h0, 17'h0, 17'h0);
        rst = 1'b0;
        @(negedge clk);

        // M=[1 1;1 2], N=[2 -1;-1 1] -> identity
        set_ops({16'h0100, 16'h0100, 16'h0100, 16'h0200},
                {16'h0200, 16'h0100, 16'h0100, 16'h0100}, 4'b0110);
        op_and_check("t1", 17'h00100, 17'h0, 17'h0, 17'h00100, 1'b0);
        check("t1 dones", dones, 1);

        set_ops({16'h0200, 16'h0000, 16'h0000, 16'h0300},
                {16'h0080, 16'h0000, 16'h0000, 16'h0055}, 4'b0000);
        op_and_check("t2", 17'h00100, 17'h0, 17'h0, 17'h000FF, 1'b0);

        set_ops({16'hFF00, 16'h0000, 16'h0000, 16'h0100},
                {16'h0100, 16'h0000, 16'h0000, 16'h0100}, 4'b0000);
        op_and_check("t3", 17'h10100, 17'h0, 17'h0, 17'h00100, 1'b0);

        set_ops({16'h7F00, 16'h7F00, 16'h0000, 16'h0000},
                {16'h7F00, 16'h0000, 16'h7F00, 16'h0000}, 4'b0000);
        op_and_check("t4 sat", 17'h0FFFF, 17'h0, 17'h0, 17'h0, 1'b1);

        set_ops({16'h0100, 16'h0100, 16'h0100, 16'h0200},
                {16'h0200, 16'h0100, 16'h0100, 16'h0100}, 4'b0110);
        op_and_check("t4 clean", 17'h00100, 17'h0, 17'h0, 17'h00100, 1'b0);

        set_ops({16'h0001, 48'h0}, {16'h0080, 48'h0}, 4'b0000);
        op_and_check("t5 half", 17'h00001, 17'h0, 17'h0, 17'h0, 1'b0);
        set_ops({16'h0001, 48'h0}, {16'h007F, 48'h0}, 4'b0000);
        op_and_check("t5 below", 17'h0, 17'h0, 17'h0, 17'h0, 1'b0);
        set_ops({16'h0001, 48'h0}, {16'h007F, 48'h0}, 4'b1000);
        op_and_check("t5 neg zero", 17'h0, 17'h0, 17'h0, 17'h0, 1'b0);
        set_ops({16'h0001, 48'h0}, {16'h0080, 48'h0}, 4'b1000);
        op_and_check("t5 neg half", 17'h10001, 17'h0, 17'h0, 17'h0, 1'b0);

        // -128 x -1 = +128; f is -0
        set_ops({16'h8000, 48'h0}, {16'h0100, 48'h0}, 4'b1100);
        op_and_check("t7 min", 17'h08000, 17'h0, 17'h0, 17'h0, 1'b0);

        // start pulsed during MAC k=3 must be ignored
        set_ops({16'h0100, 16'h0100, 16'h0100, 16'h0200},
                {16'h0200, 16'h0100, 16'h0100, 16'h0100}, 4'b0110);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        set_ops({16'h7F00, 16'h7F00, 16'h0000, 16'h0000},
                {16'h7F00, 16'h0000, 16'h7F00, 16'h0000}, 4'b0000);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6 ready", {31'd0, ready}, 1);
        check("t6 done", {31'd0, done}, 1);
        check_p("t6", 17'h00100, 17'h0, 17'h0, 17'h00100);
        check("t6 ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        check("t6 no_restart", {31'd0, ready}, 1);
        check("t6 done_pulse", {31'd0, done}, 0);

        // reset during MAC k=4 aborts with no done
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 rst ready", {31'd0, ready}, 1);
        check("t6 rst ovf", {31'd0, ovf}, 0);
        check_p("t6 rst", 17'h0, 17'h0, 17'h0, 17'h0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("t6 rst no_done", dones, 0);

        set_ops({16'h0100, 16'h0100, 16'h0100, 16'h0200},
                {16'h0200, 16'h0100, 16'h0100, 16'h0100}, 4'b0110);
        op_and_check("t6 after", 17'h00100, 17'h0, 17'h0, 17'h00100, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
